priority_encoder: RTL and testbench



---
 rtl/priority_encoder.sv | 33 +++
 tb/tb_priority_encoder.sv | 100 ++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// priority_encoder: registered 4-to-2 priority encoder (d > c > b > a) with valid flag
module priority_encoder (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y1,
  output logic y2,
  output logic valid
);
  logic [1:0] idx_d, idx_q;
  logic       valid_d, valid_q;
  // index of the highest asserted request; idle encodes to 00 and relies on valid to qualify it
  always_comb begin
    idx_d   = d ? 2'b11 : c ? 2'b10 : b ? 2'b01 : 2'b00;
    valid_d = a | b | c | d;
  end
  // single output stage; reset clears it immediately and discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end
  assign y1    = idx_q[1];
  assign y2    = idx_q[0];
  assign valid = valid_q;
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: scoreboard bench with randomized stimulus and a behavioural reference model
module tb_priority_encoder;
  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d;
  logic y1, y2, valid;
  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  priority_encoder dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .y1(y1), .y2(y2), .valid(valid)
  );

  always #5 clk = ~clk;

  // reference: scan requests from highest to lowest, return {valid, index}
  function automatic logic [2:0] model(input logic [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return {1'b1, 2'(i)};
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {valid,y1,y2}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    {d, c, b, a} = v;
    exp_q.push_back(model(v));
  endtask

  // monitor: outputs are present every cycle; compare one expectation per clock after the edge settles
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk("encode", {valid, y1, y2}, exp_q.pop_front());
  end

  initial begin
    rst_n = 1'b0;
    {d, c, b, a} = 4'b1000;
    #1 chk("rst_async", {valid, y1, y2}, 3'b000);
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_hold", {valid, y1, y2}, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    {d, c, b, a} = 4'b0001;
    exp_q.push_back(model(4'b0001));
    foreach (exp_q[i]) ;
    drive(4'b0010);
    drive(4'b0100);
    drive(4'b1000);
    drive(4'b1111);
    drive(4'b0111);
    drive(4'b0011);
    drive(4'b1001);
    drive(4'b0101);
    drive(4'b0000);
    drive(4'b0001);
    drive(4'b0001);
    drive(4'b1000);
    #1 chk("no_glitch", {valid, y1, y2}, 3'b100);
    #2 {d, c, b, a} = 4'b0010;
    #1 chk("no_comb_path", {valid, y1, y2}, 3'b100);
    {d, c, b, a} = 4'b1000;
    repeat (24) drive(4'($urandom_range(0, 15)));
    drive(4'b1000);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk("rst_mid", {valid, y1, y2}, 3'b000);
    repeat (2) begin
      {d, c, b, a} = 4'($urandom_range(1, 15));
      @(posedge clk); #2;
      chk("rst_mid_hold", {valid, y1, y2}, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    {d, c, b, a} = 4'b0100;
    exp_q.push_back(model(4'b0100));
    drive(4'b0000);
    drive(4'b1010);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
